// File: rtl/mat_wb_unit.sv
// Matrix writeback unit: arbitrates multi-row result bursts from the MU and LD
// sources, streams rows into the matrix register file and pulses the status
// table writeback on the final row of each burst.
module mat_wb_unit #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned DW   = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  // Matrix-multiply unit source
  input  logic                     mu_valid,
  input  logic [5:0]               mu_sel,
  input  logic [1:0]               mu_tag,
  input  logic [DW-1:0]            mu_data,
  output logic                     mu_ready,
  // Matrix load unit source
  input  logic                     ld_valid,
  input  logic [5:0]               ld_sel,
  input  logic [1:0]               ld_tag,
  input  logic [DW-1:0]            ld_data,
  output logic                     ld_ready,
  // Register-file write port
  input  logic                     rf_ready,
  output logic                     rf_wen,
  output logic [5:0]               rf_sel,
  output logic [$clog2(ROWS)-1:0]  rf_row,
  output logic [DW-1:0]            rf_data,
  // Status table writeback
  output logic                     wb_write,
  output logic [5:0]               wb_sel,
  output logic [1:0]               wb_tag
);

  localparam int unsigned RW = $clog2(ROWS);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;   // 0: MU owns the burst, 1: LD
  logic            prio_q, prio_d;     // 0: MU preferred on contention, 1: LD
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic [5:0]      cur_sel_q, cur_sel_d;
  logic [1:0]      cur_tag_q, cur_tag_d;

  logic            rf_wen_q, rf_wen_d;
  logic [5:0]      rf_sel_q, rf_sel_d;
  logic [RW-1:0]   rf_row_q, rf_row_d;
  logic [DW-1:0]   rf_data_q, rf_data_d;
  logic            wb_write_q, wb_write_d;
  logic [5:0]      wb_sel_q, wb_sel_d;
  logic [1:0]      wb_tag_q, wb_tag_d;

  logic            src_valid;
  logic [DW-1:0]   src_data;
  logic            accept;
  logic            last;
  logic            pick;

  // Ready depends only on state, grant and rf_ready so there is no valid->ready path
  always_comb begin
    mu_ready = (state_q == StBurst) && !grant_q && rf_ready;
    ld_ready = (state_q == StBurst) &&  grant_q && rf_ready;
  end

  // Next-state, arbitration and registered output generation
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    row_cnt_d  = row_cnt_q;
    cur_sel_d  = cur_sel_q;
    cur_tag_d  = cur_tag_q;
    rf_wen_d   = 1'b0;
    rf_sel_d   = rf_sel_q;
    rf_row_d   = rf_row_q;
    rf_data_d  = rf_data_q;
    wb_write_d = 1'b0;
    wb_sel_d   = wb_sel_q;
    wb_tag_d   = wb_tag_q;

    src_valid = grant_q ? ld_valid : mu_valid;
    src_data  = grant_q ? ld_data  : mu_data;
    accept    = (state_q == StBurst) && src_valid && rf_ready;
    last      = accept && (row_cnt_q == RW'(ROWS - 1));
    // A lone requester wins outright; the pointer only breaks ties
    pick      = (mu_valid && ld_valid) ? prio_q : ld_valid;

    case (state_q)
      StIdle: begin
        if (mu_valid || ld_valid) begin
          grant_d   = pick;
          cur_sel_d = pick ? ld_sel : mu_sel;
          cur_tag_d = pick ? ld_tag : mu_tag;
          row_cnt_d = '0;
          state_d   = StBurst;
        end
      end
      StBurst: begin
        if (accept) begin
          row_cnt_d = row_cnt_q + 1'b1;
          rf_wen_d  = 1'b1;
          rf_sel_d  = cur_sel_q;
          rf_row_d  = row_cnt_q;
          rf_data_d = src_data;
          if (last) begin
            wb_write_d = 1'b1;
            wb_sel_d   = cur_sel_q;
            wb_tag_d   = cur_tag_q;
            prio_d     = ~grant_q;
            state_d    = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset discards any partial burst
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      row_cnt_q  <= '0;
      cur_sel_q  <= '0;
      cur_tag_q  <= '0;
      rf_wen_q   <= 1'b0;
      rf_sel_q   <= '0;
      rf_row_q   <= '0;
      rf_data_q  <= '0;
      wb_write_q <= 1'b0;
      wb_sel_q   <= '0;
      wb_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      row_cnt_q  <= row_cnt_d;
      cur_sel_q  <= cur_sel_d;
      cur_tag_q  <= cur_tag_d;
      rf_wen_q   <= rf_wen_d;
      rf_sel_q   <= rf_sel_d;
      rf_row_q   <= rf_row_d;
      rf_data_q  <= rf_data_d;
      wb_write_q <= wb_write_d;
      wb_sel_q   <= wb_sel_d;
      wb_tag_q   <= wb_tag_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_sel   = rf_sel_q;
  assign rf_row   = rf_row_q;
  assign rf_data  = rf_data_q;
  assign wb_write = wb_write_q;
  assign wb_sel   = wb_sel_q;
  assign wb_tag   = wb_tag_q;

endmodule

// File: doc/mat_wb_unit.md
# mat_wb_unit

Matrix writeback unit for the tensor core. It accepts completed matrix results from the matrix-multiply unit (MU) and the matrix load unit (LD) as multi-row bursts, and arbitrates between them. It streams the rows into the matrix register file. On the final row it drives the writeback side of the matrix register status table (`wb_sel`/`wb_write`), so that table clears the busy entry the dispatch side set.

## Interface

**Parameters**
- `ROWS`, default 4: rows per matrix burst; power of two, ≥ 2.
- `DW`, default 64: row data width (4 × 16-bit elements).

**Ports**
- `CLK` in, 1: clock; all logic is on the rising edge.
- `RST` in, 1: reset; synchronous, active-high.
- `mu_valid` in, 1: MU has a row to present.
- `mu_sel` in, 6: MU destination matrix register.
- `mu_tag` in, 2: MU instruction tag.
- `mu_data` in, DW: MU row data.
- `mu_ready` out, 1: MU row accepted when `mu_valid & mu_ready`.
- `ld_valid`, `ld_sel`, `ld_tag`, `ld_data`, `ld_ready`: same as the MU ports, for the LD source.
- `rf_ready` in, 1: register-file write port can take a row this cycle.
- `rf_wen` out, 1: register-file row write strobe.
- `rf_sel` out, 6: register being written.
- `rf_row` out, log2(ROWS): row index.
- `rf_data` out, DW: row data.
- `wb_write` out, 1: one-cycle pulse that clears status for `wb_sel`.
- `wb_sel` out, 6: register whose write has completed.
- `wb_tag` out, 2: tag of the completed instruction.

## Operation

**States**
- IDLE
  - When any `*_valid` is high: grant one source, latch its `sel`/`tag` into `cur_sel`/`cur_tag`, clear `row_cnt`, go to BURST.
  - No handshake occurs in IDLE; `*_ready` = 0.
- BURST
  - The granted source's ready = `rf_ready`. The other source's ready = 0.
  - Each accepted beat increments `row_cnt`.
  - The beat accepted with `row_cnt == ROWS-1` is the last beat: go to IDLE and toggle the priority pointer.

**Arbitration**
- Round-robin, one bit.
- Reset priority = MU.
- If both sources are valid in IDLE, the prioritised one wins. If only one is valid, it wins regardless of priority.
- The pointer toggles only on burst completion, and then points at the source that did not win.

**Burst rules**
- `sel`/`tag` are sampled only at grant. Changes during a burst are ignored.
- If the granted source drops valid mid-burst, `row_cnt` holds. The burst resumes when valid returns. There is no timeout.
- If `rf_ready` is low, nothing is accepted and `row_cnt` holds.
- A source not granted is never given ready, even if `rf_ready` = 1.

**Output generation**
- An accepted beat registers `rf_wen` = 1, `rf_sel` = `cur_sel`, `rf_row` = `row_cnt`, `rf_data` = source data.
- The last beat additionally registers `wb_write` = 1, `wb_sel` = `cur_sel`, `wb_tag` = `cur_tag`.
- `rf_wen` and `wb_write` are 0 in every cycle that follows a non-accepting cycle.

**Reset**
- Forces IDLE from any state, including mid-burst. A partial burst is discarded with no `wb_write`.
- Clears `row_cnt`; priority = MU.
- Reset values: `rf_wen` = 0, `wb_write` = 0, `rf_sel` = 0, `rf_row` = 0, `rf_data` = 0, `wb_sel` = 0, `wb_tag` = 0, `mu_ready` = 0, `ld_ready` = 0.

## Timing

- Grant: valid seen in IDLE at cycle t → BURST at t+1; the first beat can be accepted at t+1.
- Each beat accepted at cycle t is visible on `rf_*` at t+1 (1-cycle registered latency).
- Last beat accepted at t → `rf_wen` (row ROWS-1) and `wb_write` both high at t+1, for exactly one cycle. State is IDLE at t+1.
- Back-to-back bursts: one IDLE bubble between them. Best case is ROWS+1 cycles per matrix.
- `*_ready` is combinational from state, grant and `rf_ready`. No path runs from `*_valid` to `*_ready`.
- Same-register writebacks from both sources are serialised in grant order. The status table sees two separate `wb_write` pulses.

## Test plan

- **Single MU burst.** MU valid with sel=5, tag=2, 4 rows, `rf_ready`=1 → grant at cycle 1; `rf_wen` at cycles 2–5 with rows 0..3 and sel=5; `wb_write` at cycle 5 only, with `wb_sel`=5, `wb_tag`=2.
- **Contention.** MU (sel=3) and LD (sel=9) both valid from reset → MU burst completes first, then 1 IDLE cycle, then LD burst. The next contention after that grants MU again (pointer alternates).
- **Back-pressure.** `rf_ready`=0 on cycles 3–4 of an MU burst → `mu_ready`=0 on those cycles, `row_cnt` holds, no duplicate or skipped row, `wb_write` is delayed by 2 cycles.
- **Valid gap and field change.** LD drops valid for 3 cycles after row 1 and changes `ld_sel` during the gap → rows 2–3 still written to the originally granted sel; exactly one `wb_write`.
- **Reset mid-burst.** `RST` asserted after row 2 of an MU burst → next cycle all outputs 0 and state IDLE; no `wb_write`; a new burst afterwards starts at row 0, and if contended, MU wins.
- **Idle source.** LD valid only with MU idle while priority points at MU → LD is granted immediately, and the pointer afterwards points at MU.
